// File: rtl/div_issue_hilo_if.sv
// div_issue_hilo_if: launch/cancel/result handshake between the issue controller and the iterative divider
interface div_issue_hilo_if;
    logic        div_en;
    logic        div_cancel;
    logic        div_sign;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic [63:0] div_result;
    logic        div_done;

    modport master (
        output div_en, div_cancel, div_sign, div_op1, div_op2,
        input  div_result, div_done
    );

    modport slave (
        input  div_en, div_cancel, div_sign, div_op1, div_op2,
        output div_result, div_done
    );
endinterface

// File: rtl/div_issue_hilo.sv
// div_issue_hilo: issues DIV/DIVU to the iterative divider, stalls EXE meanwhile, owns HI/LO
module div_issue_hilo (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   div_req,
    input  logic                   div_signed,
    input  logic [31:0]            op1,
    input  logic [31:0]            op2,
    input  logic                   flush,
    div_issue_hilo_if.master       div,
    input  logic                   hi_we,
    input  logic                   lo_we,
    input  logic [31:0]            hi_wdata,
    input  logic [31:0]            lo_wdata,
    output logic                   stall_req,
    output logic [31:0]            hi_rdata,
    output logic [31:0]            lo_rdata
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] op1_q, op1_d, op2_q, op2_d;
    logic        en_q, en_d, cancel_q, cancel_d, sign_q, sign_d;
    logic        drain_q, drain_d;
    logic        issue, commit;

    assign issue  = state_q == IDLE && div_req && !flush && !div.div_done;
    assign commit = state_q == BUSY && div.div_done && !flush;

    // Next-state and divider-control logic; DRAIN spends two cycles so the divider can settle
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        drain_d  = drain_q;
        cancel_d = 1'b0;
        case (state_q)
            IDLE: if (issue) begin
                state_d = BUSY;
                sign_d  = div_signed;
                op1_d   = op1;
                op2_d   = op2;
            end
            BUSY: if (flush) begin
                state_d  = DRAIN;
                cancel_d = 1'b1;
                drain_d  = 1'b0;
            end else if (div.div_done) begin
                state_d = COMMIT;
            end
            COMMIT: state_d = IDLE;
            default: begin
                drain_d = 1'b1;
                state_d = drain_q ? IDLE : DRAIN;
            end
        endcase
        en_d = state_d == BUSY;
    end

    // HI/LO update: a divider commit is younger than any MTHI/MTLO in the same cycle, so it wins
    always_comb begin
        hi_d = commit ? div.div_result[63:32] : hi_we ? hi_wdata : hi_q;
        lo_d = commit ? div.div_result[31:0]  : lo_we ? lo_wdata : lo_q;
    end

    // State and register file flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            en_q     <= 1'b0;
            cancel_q <= 1'b0;
            sign_q   <= 1'b0;
            drain_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            en_q     <= en_d;
            cancel_q <= cancel_d;
            sign_q   <= sign_d;
            drain_q  <= drain_d;
        end
    end

    assign stall_req      = (state_q == IDLE && div_req && !flush) || state_q == BUSY;
    assign div.div_en     = en_q;
    assign div.div_cancel = cancel_q;
    assign div.div_sign   = sign_q;
    assign div.div_op1    = op1_q;
    assign div.div_op2    = op2_q;
    assign hi_rdata       = hi_we ? hi_wdata : hi_q;
    assign lo_rdata       = lo_we ? lo_wdata : lo_q;
endmodule
